// File: rtl/traffic_sensor_front_if.sv
// Detector/controller bundle for the traffic sensor front end.
// The controller side (master) drives detectors and greens; the sensor (slave) returns counts.
interface traffic_sensor_front_if;
    logic       mainCarRaw;
    logic       sideCarRaw;
    logic       pedRaw;
    logic       MG;
    logic       SG;
    logic       pedLight;
    logic [2:0] mainTraffic;
    logic [2:0] sideTraffic;
    logic       pedButton;

    modport master (
        output mainCarRaw, sideCarRaw, pedRaw, MG, SG, pedLight,
        input  mainTraffic, sideTraffic, pedButton
    );

    modport slave (
        input  mainCarRaw, sideCarRaw, pedRaw, MG, SG, pedLight,
        output mainTraffic, sideTraffic, pedButton
    );
endinterface

// File: rtl/traffic_sensor_front.sv
// Synchronizes and debounces vehicle/pedestrian detectors, keeps per-road queue counts
// drained by green time, and latches the pedestrian request until the walk light answers it.
module traffic_sensor_front #(
    parameter int DEB_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input logic                  clk,
    input logic                  reset,
    traffic_sensor_front_if.slave bus
);

    localparam logic [3:0] DEB_LAST   = 4'(DEB_CYCLES - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    // Channel order: bit 0 main, bit 1 side, bit 2 pedestrian.
    logic [2:0]      raw_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      deb_r;
    logic [2:0]      deb_nxt_s;
    logic [2:0][3:0] cnt_r;
    logic [2:0][3:0] cnt_nxt_s;
    logic [2:0]      arrive_s;

    // Road order: bit 0 main, bit 1 side.
    logic [1:0]      green_s;
    logic [1:0][7:0] tmr_r;
    logic [1:0][7:0] tmr_nxt_s;
    logic [1:0]      depart_s;

    logic [2:0]      main_q_r;
    logic [2:0]      side_q_r;
    logic            ped_r;

    assign raw_s   = {bus.pedRaw, bus.sideCarRaw, bus.mainCarRaw};
    assign green_s = {bus.SG, bus.MG};

    // Saturating 0..7 queue step; simultaneous arrival and departure cancel.
    function automatic logic [2:0] queue_next(input logic [2:0] q, input logic arr, input logic dep);
        logic [2:0] r;
        case ({arr, dep})
            2'b10:   r = (q == 3'd7) ? q : q + 3'd1;
            2'b01:   r = (q == 3'd0) ? q : q - 3'd1;
            default: r = q;
        endcase
        return r;
    endfunction

    // Two-flop synchronizers for the asynchronous detector levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state: a level must disagree for DEB_CYCLES edges before it is accepted.
    always_comb begin
        deb_nxt_s = deb_r;
        cnt_nxt_s = cnt_r;
        arrive_s  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] == deb_r[i]) begin
                cnt_nxt_s[i] = 4'd0;
            end else if (cnt_r[i] == DEB_LAST) begin
                cnt_nxt_s[i] = 4'd0;
                deb_nxt_s[i] = sync2_r[i];
                arrive_s[i]  = sync2_r[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + 4'd1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_r <= 3'b000;
            cnt_r <= 12'h000;
        end else begin
            deb_r <= deb_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    // Drain timers: a departure every DRAIN_CYCLES edges of uninterrupted green.
    always_comb begin
        tmr_nxt_s = tmr_r;
        depart_s  = 2'b00;
        for (int j = 0; j < 2; j++) begin
            if (!green_s[j]) begin
                tmr_nxt_s[j] = 8'd0;
            end else if (tmr_r[j] == DRAIN_LAST) begin
                tmr_nxt_s[j] = 8'd0;
                depart_s[j]  = 1'b1;
            end else begin
                tmr_nxt_s[j] = tmr_r[j] + 8'd1;
            end
        end
    end

    // Drain timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_r <= 16'h0000;
        end else begin
            tmr_r <= tmr_nxt_s;
        end
    end

    // Queue counts and pedestrian latch; the walk light clears and masks new requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q_r <= 3'd0;
            side_q_r <= 3'd0;
            ped_r    <= 1'b0;
        end else begin
            main_q_r <= queue_next(main_q_r, arrive_s[0], depart_s[0]);
            side_q_r <= queue_next(side_q_r, arrive_s[1], depart_s[1]);
            if (bus.pedLight) begin
                ped_r <= 1'b0;
            end else if (arrive_s[2]) begin
                ped_r <= 1'b1;
            end else begin
                ped_r <= ped_r;
            end
        end
    end

    assign bus.mainTraffic = main_q_r;
    assign bus.sideTraffic = side_q_r;
    assign bus.pedButton   = ped_r;

endmodule
